antares_rr_mux: RTL
===================

Name: antares_rr_mux

Overview:
Registered N-input multiplexer with per-channel valid/ready handshakes and round-robin arbitration. It replaces fixed-select combinational muxing wherever several producers share one consumer, for example bus masters feeding a memory port or multiple sources feeding a writeback path. An optional packet mode holds the grant on one channel until that channel's last beat, so multi-beat transfers are never interleaved. Output is registered, giving one cycle of latency.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels; must be 2 or more.
- PACKET_MODE, 0, 1 = grant locks until a beat with in_last is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_IN  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NUM_IN  per-channel last-beat flag.
- in_ready  output  NUM_IN  per-channel accept; combinational.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  SEL_W  index of the channel that produced the current beat; SEL_W = max(1, clog2(NUM_IN)), localparam.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset (asynchronous, whenever rst_n is 0, including mid-packet):
  - out_valid, out_data, out_last, out_sel all 0.
  - Lock cleared.
  - Last-grant pointer set to NUM_IN-1, so channel 0 has first priority after reset.
- Load condition: load = !out_valid | out_ready. The register accepts a new beat when empty or being drained the same cycle. This gives full throughput: one beat per cycle while out_ready stays high.
- Arbitration (combinational, each cycle):
  - Unlocked: grant = first channel with in_valid set, searching from last_grant+1 upward and wrapping modulo NUM_IN.
  - Locked: only the lock channel is a candidate.
  - No candidate: no grant.
- in_ready[i] = load & grant_valid & (grant == i). At most one bit is set.
  - in_ready[i] may depend on in_valid in the same cycle.
  - Producers must not make in_valid depend on in_ready.
- Transfer on a channel = in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g], out_last <= in_last[g], out_sel <= g, out_valid <= 1.
  - last_grant <= g.
- load with no grant: out_valid <= 0. out_data, out_last and out_sel hold their previous values.
- !load (out_valid=1, out_ready=0): all outputs hold; in_ready all 0 (backpressure).
- Packet mode (PACKET_MODE=1):
  - Transfer with in_last=0 sets lock to channel g.
  - Transfer with in_last=1 clears the lock.
  - While locked, if the lock channel deasserts in_valid, no channel is granted. Other channels stall; lock persists.
  - A single-beat packet (in_last=1 on the first beat) never locks.
- PACKET_MODE=0: in_last is passed through to out_last only; it never locks.
- Latency: beat accepted at edge N appears at outputs after edge N, one cycle, no combinational input-to-output data path.
- Data stability: out_data, out_last and out_sel are stable while out_valid=1 and out_ready=0.
- Fairness: with all channels continuously requesting and out_ready=1, beats rotate 0,1,...,NUM_IN-1,0,...
- in_data bits of non-granted channels are don't-care. X on them must not propagate.

Test Plan:
1. Reset, then in_valid=4'b0100, in_data ch2=32'hCAFE0002, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hCAFE0002, out_sel=2.
2. All four valid continuously, out_ready=1, PACKET_MODE=0 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
3. Backpressure: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> in_ready=0, outputs frozen for 3 cycles. On out_ready=1, ch1 is accepted in the same cycle.
4. PACKET_MODE=1:
   - ch0 sends 3 beats with in_last on beat 3; ch1 valid throughout -> out_sel=0,0,0, then 1.
   - Repeat with ch0 dropping in_valid after beat 1 -> no output beat on ch1 until ch0 completes its last beat.
5. Single-beat packets on ch3 and ch0, PACKET_MODE=1 -> grants alternate 0,3 and no lock is taken.
6. Assert rst_n=0 mid-packet while locked on ch2 -> outputs 0 and lock cleared asynchronously. After release with ch0 and ch2 valid, ch0 is granted first.

Source files
------------

// File: rtl/antares_rr_mux.sv
// Registered N-input mux with per-channel valid/ready handshakes and round-robin arbitration.
// An optional packet mode holds the grant on one channel until that channel's last beat.
module antares_rr_mux #(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 4,
  parameter int PACKET_MODE = 0,
  localparam int SEL_W      = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic             lock_q,      lock_d;
  logic [SEL_W-1:0] lock_ch_q,   lock_ch_d;

  logic             load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic             hi_found;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_found;
  logic [SEL_W-1:0] lo_idx;
  logic             lock_req;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // The output register takes a beat when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  // Round-robin search: the lowest requester above last_grant wins, otherwise
  // the lowest requester overall (the wrap-around case).
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch for the paths that leave it unassigned.
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    lock_req = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
      end
      if (lock_ch_q == SEL_W'(i)) begin
        lock_req = in_valid[i];
      end
    end

    if (lock_q) begin
      grant_valid = lock_req;
      grant       = lock_ch_q;
    end else begin
      grant_valid = lo_found;
      grant       = hi_found ? hi_idx : lo_idx;
    end
  end

  // Only the granted channel's lane is selected, so X on other lanes is masked.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load && grant_valid;
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_last    = in_last[i];
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    lock_ch_d    = lock_ch_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d   = sel_data;
        out_last_d   = sel_last;
        out_sel_d    = grant;
        last_grant_d = grant;
        // A beat without last opens (or keeps) a lock; a last beat releases it.
        if (PACKET_MODE != 0) begin
          lock_d    = !sel_last;
          lock_ch_d = grant;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, because the block must present
      // all-zero outputs while in reset rather than whatever was last loaded.
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
      lock_q       <= 1'b0;
      lock_ch_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
